// File: rtl/regfile_pkg.sv
// Shared register-file constants and address helpers used by the writeback
// arbiter and anything else that drives the MIPS register file write port.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 6;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

    // True for addresses that name a physical register (r0 included).
    function automatic logic addr_in_range(input logic [31:0] addr);
        return addr < 32'(NUM_REGS);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer,
// pointer moves past the winner whenever the grant is consumed.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any,
    output logic [PTR_W-1:0] ptr
);
    import regfile_pkg::*;

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_any) begin
            ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between writeback requesters:
// round-robin grant, one-entry output register, r0/range filter, RAW hazards.
module regfile_write_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     w_en,
    output logic [ADDR_W-1:0]        addr_w,
    output logic [DATA_W-1:0]        w_data,
    input  logic [ADDR_W-1:0]        rd_addr_1,
    input  logic [ADDR_W-1:0]        rd_addr_2,
    output logic                     hazard_1,
    output logic                     hazard_2,
    output logic                     addr_err
);
    import regfile_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic [PTR_W-1:0]  rr_ptr;
    logic              xfer;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic              g_in_range;
    logic              g_nonzero;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any),
        .ptr       (rr_ptr)
    );

    // Grant is suppressed asynchronously so nothing transfers during reset.
    assign req_ready = rst ? '0 : grant;
    assign xfer      = grant_any & ~rst;

    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                g_addr = req_addr[i*ADDR_W +: ADDR_W];
                g_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign g_in_range = addr_in_range(32'(g_addr));
    assign g_nonzero  = (g_addr != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en     <= 1'b0;
            addr_w   <= '0;
            w_data   <= '0;
            addr_err <= 1'b0;
        end else if (xfer) begin
            w_en   <= g_in_range & g_nonzero;
            addr_w <= g_addr;
            w_data <= g_data;
            if (!g_in_range) begin
                addr_err <= 1'b1;
            end
        end else begin
            w_en <= 1'b0;
        end
    end

    // A read hazards on any pending request or the write sitting in the output stage.
    always_comb begin
        hazard_1 = 1'b0;
        hazard_2 = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_addr[i*ADDR_W +: ADDR_W] == rd_addr_1) hazard_1 = 1'b1;
            if (req_valid[i] && req_addr[i*ADDR_W +: ADDR_W] == rd_addr_2) hazard_2 = 1'b1;
        end
        if (w_en && addr_w == rd_addr_1) hazard_1 = 1'b1;
        if (w_en && addr_w == rd_addr_2) hazard_2 = 1'b1;
        if (rd_addr_1 == '0) hazard_1 = 1'b0;
        if (rd_addr_2 == '0) hazard_2 = 1'b0;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference arbiter predicts the
// grant and queues the expected output-stage contents for the following cycle.
module tb_regfile_write_arbiter;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 6;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic [N-1:0]    req_ready;
    logic            w_en;
    logic [AW-1:0]   addr_w;
    logic [DW-1:0]   w_data;
    logic [AW-1:0]   rd_addr_1 = '0;
    logic [AW-1:0]   rd_addr_2 = '0;
    logic            hazard_1, hazard_2, addr_err;

    exp_t sb[$];
    int   m_ptr  = 0;
    logic m_err  = 1'b0;
    int   last_g = -1;
    int   n_chk  = 0;
    int   n_err  = 0;

    regfile_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .w_en(w_en), .addr_w(addr_w),
        .w_data(w_data), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .hazard_1(hazard_1), .hazard_2(hazard_2), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic model_reset();
        sb.delete();
        sb.push_back('0);
        m_ptr  = 0;
        m_err  = 1'b0;
        last_g = -1;
    endtask

    // One clock: compare at the falling edge, then advance the model.
    task automatic tick();
        exp_t          cur, nxt;
        logic [N-1:0]  eg;
        logic          h1, h2;
        logic [AW-1:0] ga;
        int            g;
        @(negedge clk);
        cur = sb.pop_front();
        eg  = '0;
        g   = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        if (g >= 0) eg[g] = 1'b1;
        h1 = 1'b0;
        h2 = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_addr[i*AW +: AW] == rd_addr_1) h1 = 1'b1;
            if (req_valid[i] && req_addr[i*AW +: AW] == rd_addr_2) h2 = 1'b1;
        end
        if (cur.wen && cur.addr == rd_addr_1) h1 = 1'b1;
        if (cur.wen && cur.addr == rd_addr_2) h2 = 1'b1;
        if (rd_addr_1 == 0) h1 = 1'b0;
        if (rd_addr_2 == 0) h2 = 1'b0;
        chk("req_ready", 64'(req_ready), 64'(eg));
        chk("w_en",      64'(w_en),      64'(cur.wen));
        chk("addr_w",    64'(addr_w),    64'(cur.addr));
        chk("w_data",    64'(w_data),    64'(cur.data));
        chk("addr_err",  64'(addr_err),  64'(m_err));
        chk("hazard_1",  64'(hazard_1),  64'(h1));
        chk("hazard_2",  64'(hazard_2),  64'(h2));
        nxt     = cur;
        nxt.wen = 1'b0;
        if (g >= 0) begin
            ga       = req_addr[g*AW +: AW];
            nxt.addr = ga;
            nxt.data = req_data[g*DW +: DW];
            nxt.wen  = (ga != 0) && (ga < 32);
            if (ga >= 32) m_err = 1'b1;
            m_ptr = (g + 1) % N;
        end
        last_g = g;
        sb.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with every requester valid.
        set_req(0, 1'b1, 6'd1, 32'h11);
        set_req(1, 1'b1, 6'd2, 32'h22);
        set_req(2, 1'b1, 6'd3, 32'h33);
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_w_en",  64'(w_en),      64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Round robin: grants 0,1,2,0,1,2 then the writes drain.
        repeat (6) tick();
        req_valid = '0;
        tick();

        // Single write from requester 1.
        set_req(1, 1'b1, 6'd10, 32'h0000AAAA);
        rd_addr_1 = 6'd10;
        tick();
        req_valid = '0;
        tick();
        tick();

        // r0 write is accepted and silently dropped.
        set_req(0, 1'b1, 6'd0, 32'hFFFF);
        rd_addr_1 = 6'd0;
        tick();
        req_valid = '0;
        tick();

        // Out-of-range write raises the sticky flag; later legal writes leave it set.
        set_req(2, 1'b1, 6'd40, 32'h4040);
        tick();
        req_valid = '0;
        tick();
        set_req(0, 1'b1, 6'd5, 32'h5555);
        tick();
        req_valid = '0;
        tick();

        // Hazards on both read ports, including address 0 masking.
        set_req(2, 1'b1, 6'd7, 32'h7777);
        rd_addr_1 = 6'd7;
        rd_addr_2 = 6'd7;
        tick();
        req_valid = '0;
        tick();
        rd_addr_1 = 6'd0;
        set_req(2, 1'b1, 6'd7, 32'h7778);
        tick();
        req_valid = '0;

        // Reset lands while the output stage holds a live write.
        chk("pre_rst_w_en", 64'(w_en), 64'(sb[0].wen));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_w_en",  64'(w_en),  64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        chk("midrst_ptr",   64'(u_dut.rr_ptr), 64'd0);
        chk("midrst_err",   64'(addr_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        req_valid = '1;
        tick();
        tick();

        // Random traffic; a requester only changes its request after a grant or while idle.
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_g == i)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom);
            end
            rd_addr_1 = AW'($urandom_range(0, 15));
            rd_addr_2 = AW'($urandom_range(0, 15));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the MIPS register file (`w_en`, `addr_w`, `w_data`) between several writeback requesters, such as the ALU result, the memory load return and the link-address writer. It uses round-robin arbitration behind a one-entry output register. It also discards writes to r0 and out-of-range addresses. It reports read-after-write hazards so the pipeline sequencer can stall reads on either register file read port.

## Interface

Parameters:
- `N_REQ`, 3: number of writeback requesters (2..8).
- `DATA_W`, 32: register data width.
- `ADDR_W`, 6: register address width, matching the register file address ports.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  N_REQ: request i holds a write.
- `req_addr`  in  N_REQ*ADDR_W: destination register of request i; slice i is `[i*ADDR_W +: ADDR_W]`.
- `req_data`  in  N_REQ*DATA_W: write data of request i; packed the same way as `req_addr`.
- `req_ready`  out  N_REQ: one-hot grant. Request i transfers in a cycle with `req_valid[i] & req_ready[i]`.
- `w_en`  out  1: register file write enable.
- `addr_w`  out  ADDR_W: register file write address.
- `w_data`  out  DATA_W: register file write data.
- `rd_addr_1`, `rd_addr_2`  in  ADDR_W: addresses the sequencer is about to read on read ports 1 and 2.
- `hazard_1`, `hazard_2`  out  1: a write to that address is still in flight.
- `addr_err`  out  1: sticky flag; an out-of-range address (>= 32) was accepted.

## Operation

- **State:**
  - Round-robin pointer `rr_ptr` (0..N_REQ-1).
  - Output stage: `w_en`, `addr_w`, `w_data`.
  - `addr_err`.
- **Arbitration:**
  - Search starts at `rr_ptr` and wraps modulo N_REQ. The first index with `req_valid` set is granted.
  - `req_ready` is combinational and at most one bit is set. No bit is set when no request is valid or while `rst` is high.
- **Pointer update:** after a grant to index g, `rr_ptr <= (g+1) mod N_REQ`. With no grant, `rr_ptr` holds.
- **Fairness bound:** a continuously valid request is granted within N_REQ cycles.
- **Output stage:**
  - Every transfer loads the output stage. `addr_w` and `w_data` take the granted slices.
  - `w_en` is set to 1 only if the address is in 1..31.
  - A cycle with no transfer loads `w_en = 0`; `addr_w` and `w_data` hold.
  - The register file always accepts a write, so the output stage never back-pressures.
- **Dropped writes:**
  - Address 0 (r0): the request is accepted and `w_en` stays 0. This is silent; `addr_err` is unchanged.
  - Address 32..63: the request is accepted, `w_en` stays 0, and `addr_err <= 1`. The flag holds until reset.
- **Protocol:**
  - A requester holds valid, addr and data stable until it is granted.
  - Dropping valid before a grant is legal and has no effect.
- **Same-address requests in one cycle:** they are serialized in grant order, so the last-granted value ends up in the register. Requesters that need program order must serialize upstream.
- **Hazard (combinational):** `hazard_k` is 1 when `rd_addr_k` is nonzero and either of these holds:
  - some `req_valid[i]` has `req_addr[i] == rd_addr_k`;
  - `w_en == 1` and `addr_w == rd_addr_k`.

## Timing

- **Reset values:**
  - `w_en = 0`, `addr_w = 0`, `w_data = 0`.
  - `rr_ptr = 0`, `addr_err = 0`.
  - `req_ready` is forced to all zeros while `rst` is high.
- **Latency:** a transfer in cycle t drives `w_en`/`addr_w`/`w_data` during cycle t+1. The register file captures it at the rising edge that ends cycle t+1. Data is readable from cycle t+2.
- **Throughput:** one accepted write per cycle.
- **Reset mid-operation:** an output-stage write with `w_en = 1` is cleared asynchronously and never reaches the register file. Any grant in progress is aborted.
- **Wrap-around:** when the pointer is at N_REQ-1 and grants index N_REQ-1, the next search starts at 0.

## Structure

- **Shared package `regfile_pkg`:**
  - `DATA_W = 32`, `ADDR_W = 6`, `NUM_REGS = 32`, `ZERO_REG = 0`.
  - Function `addr_in_range(addr)`.
- **Sub-module `rr_arbiter`:**
  - Parameter: `N_REQ`.
  - Inputs: `req`, `advance`. Outputs: one-hot `grant` and the pointer register.
  - The top level instantiates it once and adds the output stage, the r0/range filter and the hazard comparators.

## Test plan

1. **Reset:** hold `rst = 1` with all `req_valid = 1`.
   - During reset: `req_ready = 0` and `w_en = 0`.
   - First cycle after release: `req_ready = 001`.
2. **Single write:** req1 valid, addr 10, data 0x0000AAAA in cycle t.
   - `req_ready = 010` in cycle t.
   - In cycle t+1: `w_en = 1`, `addr_w = 10`, `w_data = 0x0000AAAA`.
   - In cycle t+2, read port 1 at address 10 returns 0x0000AAAA.
3. **Round-robin:** all three requests continuously valid, with addresses 1, 2, 3 and data 0x11, 0x22, 0x33.
   - Grants cycle 0, 1, 2, 0, 1, 2.
   - `addr_w` sequence is 1, 2, 3, 1, 2, 3, with `w_en` held at 1.
4. **r0 write:** addr 0, data 0xFFFF.
   - The request is granted, `w_en` stays 0 and `addr_err = 0`.
   - A read of r0 returns 0.
5. **Out-of-range write:** addr 40.
   - The request is granted, `w_en` stays 0 and `addr_err = 1`.
   - `addr_err` stays 1 through later legal writes and clears only on reset.
6. **Hazard and mid-reset:**
   - req2 valid with addr 7 and `rd_addr_1 = 7`: `hazard_1 = 1`.
   - Same condition with `rd_addr_1 = 0`: `hazard_1 = 0`.
   - Assert `rst` while `w_en = 1`: `w_en` drops in the same cycle and `rr_ptr = 0`.
